// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM.
// Fetches and decodes each instruction and sequences the datapath muxes,
// register file, memory port and ALU.
//
// Parameters:
//   ALU_SETTLE  cycles each ALU state (MEM_ADDR, R_EXEC, BRANCH, I_EXEC) holds, 1..4
// Ports:
//   clk, rst_n          clock, async active-low reset
//   opcode, funct       instruction register fields
//   zero                ALU zero flag; the datapath qualifies pc_write_cond with it
//   mem_ready           memory completes the current read/write this cycle
//   pc_write .. alu_src_a  1-bit datapath controls
//   alu_src_b, pc_source   2-bit mux selects
//   alu_control         4-bit ALU op
//   state               current state (debug)
//   illegal             trap indicator
// Configuration macro:
//   MC_ILLEGAL_TRAP_EN  illegal opcode/funct parks in TRAP until reset;
//                       when undefined it executes as a NOP.
module mips_multicycle_control #(
   parameter int unsigned ALU_SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [3:0] alu_control,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ALU_SETTLE - 1);

`ifdef MC_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_DEST = S_TRAP;
`else
   localparam state_t ILLEGAL_DEST = S_FETCH;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             is_alu_state;
   logic             settle_done;
   logic             funct_ok;
   logic [3:0]       r_alu_op;

   // zero is consumed by the datapath's PC enable, not by the sequencing
   logic unused_zero;
   assign unused_zero = zero;

   assign state        = state_q;
   assign is_alu_state = (state_q == S_MEM_ADDR) || (state_q == S_R_EXEC) ||
                         (state_q == S_BRANCH)   || (state_q == S_I_EXEC);
   assign settle_done  = (cnt_q == SETTLE_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // ALU settle counter, cleared on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt_q <= '0;
      else if (state_d != state_q)  cnt_q <= '0;
      else if (is_alu_state)        cnt_q <= cnt_q + CNT_W'(1);
   end

   // R-type funct decode
   always_comb begin
      funct_ok = 1'b1;
      r_alu_op = ALU_ADD;
      case (funct)
         6'h20:   r_alu_op = ALU_ADD;
         6'h22:   r_alu_op = ALU_SUB;
         6'h24:   r_alu_op = ALU_AND;
         6'h25:   r_alu_op = ALU_OR;
         6'h27:   r_alu_op = ALU_NOR;
         6'h2A:   r_alu_op = ALU_SLT;
         6'h00:   r_alu_op = ALU_SLL;
         6'h18:   r_alu_op = ALU_MUL;
         default: funct_ok = 1'b0;
      endcase
   end

   // Next state and Moore control decode
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_control   = ALU_ADD;
      illegal       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // strobes must stay quiet while reset is held
            if (mem_ready) begin
               ir_write = rst_n;
               pc_write = rst_n;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_I_EXEC;
               default:      state_d = ILLEGAL_DEST;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (settle_done) state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_R_EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = r_alu_op;
            if (settle_done) state_d = funct_ok ? S_R_WB : ILLEGAL_DEST;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_source   = 2'b01;
            // only the last cycle sees a settled zero flag
            pc_write_cond = settle_done;
            if (settle_done) state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (settle_done) state_d = S_I_WB;
         end
         S_I_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal = 1'b1;
            state_d = S_TRAP;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

endmodule
